neuron_tdm_scheduler: RTL and testbench

- Time-multiplexes one LIF update datapath across N_NEURONS virtual neurons held in internal state registers.
- Between timesteps it accepts synaptic current writes into per-neuron accumulators.
- On tick_start it scans every neuron once, applying leak, integration, threshold and refractory reset.
- Spikes are emitted as indexed events over a valid/ready handshake. Sits between synapse logic and the spike router.

---
 rtl/neuro_pkg.sv | 28 ++
 rtl/lif_update_core.sv | 39 +++
 rtl/neuron_tdm_scheduler.sv | 147 ++++++++++++++
 tb/tb_neuron_tdm_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuro_pkg.sv
// Shared definitions for time-multiplexed LIF neuron cores.
// Provides default threshold/leak constants, the scheduler FSM encoding and the
// 8-bit saturating arithmetic helpers used by the LIF update datapath.
package neuro_pkg;

  localparam logic [7:0] DefThreshold = 8'd127;
  localparam logic [7:0] DefLeak      = 8'd5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

  // a + b computed 9-bit wide, clamped to 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // a - b, floored at 0.
  function automatic logic [7:0] clamp_sub8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? 8'd0 : (a - b);
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational leaky integrate-and-fire update for one neuron.
// Ports:
//   v         current membrane potential
//   acc       synaptic current accumulated since the last timestep
//   refr      neuron is refractory this timestep
//   v_next    membrane potential after the update
//   refr_next refractory flag after the update
//   fire      neuron spikes this timestep (never while refractory)
module lif_update_core import neuro_pkg::*; #(
  parameter logic [7:0] THRESHOLD = DefThreshold,
  parameter logic [7:0] LEAK      = DefLeak
) (
  input  logic [7:0] v,
  input  logic [7:0] acc,
  input  logic       refr,
  output logic [7:0] v_next,
  output logic       refr_next,
  output logic       fire
);

  logic [7:0] leaked;
  logic [7:0] integ;

  always_comb begin
    leaked    = clamp_sub8(v, LEAK);
    integ     = sat_add8(leaked, acc);
    v_next    = integ;
    refr_next = 1'b0;
    fire      = 1'b0;
    if (refr) begin
      // Refractory neuron discards its input and rests at 0.
      v_next = 8'd0;
    end else if (integ > THRESHOLD) begin
      refr_next = 1'b1;
      fire      = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_tdm_scheduler.sv
// Time-multiplexes one LIF update core across N_NEURONS virtual neurons.
// In idle, synaptic currents accumulate per neuron; tick_start scans every
// neuron once (one per cycle) and emits spikes as indexed valid/ready events.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   tick_start/busy/done     timestep control and status
//   cur_valid/idx/value/ready  current write port (accepted only in idle)
//   spike_valid/idx/ready    spike event output, one outstanding at most
//   mon_idx/mon_vmem         combinational membrane potential readback
module neuron_tdm_scheduler import neuro_pkg::*; #(
  parameter int unsigned N_NEURONS = 16,
  parameter int unsigned IDX_W     = 4,
  parameter logic [7:0]  THRESHOLD = DefThreshold,
  parameter logic [7:0]  LEAK      = DefLeak
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_start,
  output logic             busy,
  output logic             done,
  input  logic             cur_valid,
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [7:0]       cur_value,
  output logic             cur_ready,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  input  logic             spike_ready,
  input  logic [IDX_W-1:0] mon_idx,
  output logic [7:0]       mon_vmem
);

  sched_state_e           state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             v_mem_q [N_NEURONS];
  logic [7:0]             v_mem_d [N_NEURONS];
  logic [7:0]             acc_q   [N_NEURONS];
  logic [7:0]             acc_d   [N_NEURONS];
  logic [N_NEURONS-1:0]   refr_q, refr_d;
  logic                   spike_valid_q, spike_valid_d;
  logic [IDX_W-1:0]       spike_idx_q, spike_idx_d;

  logic [7:0] core_v_next;
  logic       core_refr_next;
  logic       core_fire;
  logic       spike_free;
  logic       stall;
  logic       last_idx;

  lif_update_core #(
    .THRESHOLD(THRESHOLD),
    .LEAK     (LEAK)
  ) u_core (
    .v        (v_mem_q[idx_q]),
    .acc      (acc_q[idx_q]),
    .refr     (refr_q[idx_q]),
    .v_next   (core_v_next),
    .refr_next(core_refr_next),
    .fire     (core_fire)
  );

  assign spike_free = spike_valid_q & spike_ready;
  // A new spike can only be loaded if the register is empty or drains this cycle.
  assign stall      = core_fire & spike_valid_q & ~spike_ready;
  assign last_idx   = (idx_q == IDX_W'(N_NEURONS - 1));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    v_mem_d       = v_mem_q;
    acc_d         = acc_q;
    refr_d        = refr_q;
    spike_valid_d = spike_valid_q;
    spike_idx_d   = spike_idx_q;

    if (spike_free) begin
      spike_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cur_valid) begin
          acc_d[cur_idx] = sat_add8(acc_q[cur_idx], cur_value);
        end
        if (tick_start) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        if (!stall) begin
          v_mem_d[idx_q] = core_v_next;
          refr_d[idx_q]  = core_refr_next;
          acc_d[idx_q]   = 8'd0;
          if (core_fire) begin
            spike_valid_d = 1'b1;
            spike_idx_d   = idx_q;
          end
          if (last_idx) begin
            state_d = StDrain;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (!spike_valid_q || spike_ready) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      refr_q        <= '0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem_q[i] <= 8'd0;
        acc_q[i]   <= 8'd0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      v_mem_q       <= v_mem_d;
      acc_q         <= acc_d;
      refr_q        <= refr_d;
      spike_valid_q <= spike_valid_d;
      spike_idx_q   <= spike_idx_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign cur_ready   = (state_q == StIdle);
  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign mon_vmem    = v_mem_q[mon_idx];

endmodule

// File: tb/tb_neuron_tdm_scheduler.sv
// Scoreboard bench for neuron_tdm_scheduler: a timestep-level reference model
// pushes expected spike indices; an independent monitor pops them on every
// accepted spike event.
module tb_neuron_tdm_scheduler;

  localparam int N   = 16;
  localparam int IW  = 4;
  localparam int THR = 127;
  localparam int LK  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick_start;
  logic          busy;
  logic          done;
  logic          cur_valid;
  logic [IW-1:0] cur_idx;
  logic [7:0]    cur_value;
  logic          cur_ready;
  logic          spike_valid;
  logic [IW-1:0] spike_idx;
  logic          spike_ready;
  logic [IW-1:0] mon_idx;
  logic [7:0]    mon_vmem;

  neuron_tdm_scheduler #(
    .N_NEURONS(N),
    .IDX_W    (IW),
    .THRESHOLD(8'd127),
    .LEAK     (8'd5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_start (tick_start),
    .busy       (busy),
    .done       (done),
    .cur_valid  (cur_valid),
    .cur_idx    (cur_idx),
    .cur_value  (cur_value),
    .cur_ready  (cur_ready),
    .spike_valid(spike_valid),
    .spike_idx  (spike_idx),
    .spike_ready(spike_ready),
    .mon_idx    (mon_idx),
    .mon_vmem   (mon_vmem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  int m_v   [N];
  int m_acc [N];
  bit m_refr[N];
  int exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: hold for hold_left cycles
  int hold_left  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_acc[i] = 0; m_refr[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_write(input int idx, input int val);
    m_acc[idx] = (m_acc[idx] + val > 255) ? 255 : m_acc[idx] + val;
  endtask

  task automatic model_tick();
    int l, s;
    for (int i = 0; i < N; i++) begin
      l = (m_v[i] < LK) ? 0 : m_v[i] - LK;
      s = l + m_acc[i];
      if (s > 255) s = 255;
      if (m_refr[i]) begin
        m_v[i] = 0; m_refr[i] = 0;
      end else if (s > THR) begin
        m_v[i] = s; m_refr[i] = 1; exp_q.push_back(i);
      end else begin
        m_v[i] = s;
      end
      m_acc[i] = 0;
    end
  endtask

  // spike_ready driver
  initial begin
    spike_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: spike_ready = 1'b1;
        1: spike_ready = 1'($urandom_range(0, 1));
        default: begin
          if (spike_valid && hold_left > 0) begin
            spike_ready = 1'b0;
            hold_left--;
          end else begin
            spike_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: scoreboard pops on accepted spikes, checks hold stability
  initial begin
    bit            prev_hold;
    logic [IW-1:0] prev_idx;
    prev_hold = 0;
    prev_idx  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 0;
        continue;
      end
      if (prev_hold) begin
        chk("hold_valid", spike_valid, 1);
        chk("hold_idx", spike_idx, prev_idx);
      end
      if (done) done_cnt++;
      if (spike_valid && spike_ready) begin
        if (exp_q.size() == 0) chk("unexpected_spike", spike_idx, -1);
        else chk("spike_idx", spike_idx, exp_q.pop_front());
      end
      prev_hold = spike_valid && !spike_ready;
      prev_idx  = spike_idx;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_vmem();
    for (int i = 0; i < N; i++) begin
      mon_idx = IW'(i);
      #1;
      chk($sformatf("vmem[%0d]", i), mon_vmem, m_v[i]);
    end
  endtask

  task automatic wr(input int idx, input int val);
    @(posedge clk); #1;
    cur_valid = 1'b1;
    cur_idx   = IW'(idx);
    cur_value = 8'(val);
    chk("cur_ready_idle", cur_ready, 1);
    model_write(idx, val);
    @(posedge clk); #1;
    cur_valid = 1'b0;
  endtask

  // exp_lat = 0 skips the latency comparison; wr_idx < 0 means no same-cycle write
  task automatic tick(input int exp_lat, input int wr_idx, input int wr_val);
    int t0, tdone;
    bit seen;
    @(posedge clk); #1;
    tick_start = 1'b1;
    if (wr_idx >= 0) begin
      cur_valid = 1'b1;
      cur_idx   = IW'(wr_idx);
      cur_value = 8'(wr_val);
      model_write(wr_idx, wr_val);
    end
    t0 = cyc;
    model_tick();
    @(posedge clk); #1;
    tick_start = 1'b0;
    cur_valid  = 1'b0;
    chk("busy_in_scan", busy, 1);
    chk("cur_ready_in_scan", cur_ready, 0);
    seen  = 0;
    tdone = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen  = 1;
        tdone = cyc;
      end
    end
    chk("done_seen", seen, 1);
    if (seen && exp_lat > 0) chk("latency", tdone - t0, exp_lat);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("spikes_drained", exp_q.size(), 0);
    check_vmem();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int dc0, nw;
    rst        = 1'b1;
    tick_start = 1'b0;
    cur_valid  = 1'b0;
    cur_idx    = '0;
    cur_value  = '0;
    mon_idx    = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_spike_valid", spike_valid, 0);
    chk("rst_spike_idx", spike_idx, 0);
    chk("rst_cur_ready", cur_ready, 1);
    check_vmem();
    rst = 1'b0;

    // Integrate and leak
    wr(3, 100);
    tick(18, -1, 0);
    tick(18, -1, 0);
    chk("leak_95", m_v[3], 95);

    // Spike and refractory
    wr(2, 200);
    tick(18, -1, 0);
    wr(2, 50);
    tick(18, -1, 0);
    tick(18, -1, 0);

    // Saturation
    wr(0, 200);
    wr(0, 200);
    tick(18, -1, 0);

    // Leak floor
    wr(5, 3);
    tick(18, -1, 0);
    tick(18, -1, 0);

    // Backpressure: first event held 5 cycles, neuron 4 stalls 3 cycles -> 18 + 3
    do_reset();
    ready_mode = 2;
    hold_left  = 5;
    wr(1, 150);
    wr(4, 150);
    tick(21, -1, 0);
    ready_mode = 0;

    // Reset mid-scan while neuron 7 is being processed
    wr(9, 20);
    @(posedge clk); #1;
    tick_start = 1'b1;
    @(posedge clk); #1;
    tick_start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    dc0 = done_cnt;
    rst = 1'b1;
    model_clear();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_spike_valid", spike_valid, 0);
    chk("midrst_spike_idx", spike_idx, 0);
    check_vmem();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_cur_ready", cur_ready, 1);
    repeat (25) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, dc0);
    tick(18, 7, 200);

    // Randomized timesteps with random backpressure
    ready_mode = 1;
    for (int t = 0; t < 12; t++) begin
      nw = $urandom_range(0, 6);
      for (int w = 0; w < nw; w++) wr($urandom_range(0, N - 1), $urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) tick(0, $urandom_range(0, N - 1), $urandom_range(0, 255));
      else tick(0, -1, 0);
    end
    ready_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
